regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, per-requester write-back FIFO depth (legal values 1..4).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_valid  input  1  requester A (ALU write-back) has a write.
REQ-005 a_ready  output  1  requester A FIFO can accept.
REQ-006 a_addr  input  5  requester A destination register.
REQ-007 a_data  input  32  requester A write data.
REQ-008 b_valid  input  1  requester B (load write-back) has a write.
REQ-009 b_ready  output  1  requester B FIFO can accept.
REQ-010 b_addr  input  5  requester B destination register.
REQ-011 b_data  input  32  requester B write data.
REQ-012 wr_en  output  1  register file write enable (drives WE).
REQ-013 wr_addr  output  5  register file write address (drives ND).
REQ-014 wr_data  output  32  register file write data (drives DI).
REQ-015 pend_mask  output  32  bit i set while any queued entry targets register i.
REQ-016 grant_b  output  1  registered; 1 when the current wr_* cycle came from B.

Function
REQ-017 Each requester SHALL own a DEPTH-entry FIFO of {addr, data}, in-order.
REQ-018 x_ready SHALL equal (count_x < DEPTH), decoded from registered count only; no pop-to-push bypass.
REQ-019 Push on posedge when x_valid && x_ready; x_valid without ready SHALL be ignored, no state change.
REQ-020 Simultaneous push and pop on one FIFO SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-021 Each cycle at most one FIFO head SHALL be popped; arbiter state: last_grant (A or B).
REQ-022 Only A non-empty -> pop A; only B non-empty -> pop B; both -> pop the one not equal to last_grant; last_grant updates only on a pop.
REQ-023 wr_en, wr_addr, wr_data, grant_b SHALL be registered from the popped head and held stable for the whole following cycle, so a negedge-writing register file samples settled values.
REQ-024 Latency: entry pushed at edge N into empty FIFO, no contention -> popped at edge N+1, wr_en high during cycle N+1..N+2.
REQ-025 Popped head with addr == 0 SHALL be consumed with wr_en = 0 (write to r0 discarded); wr_addr/wr_data still update.
REQ-026 No pop in a cycle -> wr_en = 0 next cycle; wr_addr, wr_data, grant_b hold previous values.
REQ-027 pend_mask SHALL be combinational from valid FIFO entries only, bit 0 forced 0; entry clears the cycle after its pop edge.
REQ-028 Same address queued in both FIFOs SHALL be written in arbitration order; no merging or reordering within a FIFO.
REQ-029 Throughput: one write per cycle sustained while any FIFO non-empty.

Reset
REQ-030 rst_n low SHALL immediately clear both FIFOs (counts 0, pointers 0), wr_en = 0, wr_addr = 0, wr_data = 0, grant_b = 0, last_grant = B (A wins first tie).
REQ-031 Reset mid-operation SHALL discard all queued entries; a_ready = b_ready = 1 while in reset; no push is accepted while rst_n low.
REQ-032 Release of rst_n SHALL take effect at the next posedge clk without spurious wr_en.

Verification
REQ-033 Reset, then A pushes (addr 5, 0x0000_00AA) at edge 1 -> wr_en = 1, wr_addr = 5, wr_data = 0xAA in cycle after edge 2; pend_mask = 0x20 between edges 1 and 2.
REQ-034 A and B push each cycle (A addr 1..4, B addr 9..12) -> wr_addr sequence 1,9,2,10,3,11,4,12, grant_b alternates 0,1,...
REQ-035 B holds valid with stalled drain (A also full): after DEPTH=2 pushes b_ready = 0; third b_valid ignored; exactly 2 B writes observed.
REQ-036 A pushes addr 0 data 0xFFFF_FFFF -> entry consumed, wr_en stays 0, pend_mask stays 0.
REQ-037 rst_n asserted with both FIFOs full -> wr_en = 0 and pend_mask = 0 immediately; after release no stale write appears.
REQ-038 A and B both push addr 7 (A 0x11, B 0x22) at same edge after reset -> A writes 0x11 first, then B writes 0x22; final r7 = 0x22.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two in-order {addr,data} FIFOs (ALU = A, load = B) share one
// register-file write port with round-robin tie-break and a pending-register mask.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] pend_mask,
  output logic        grant_b
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Index 0 is requester A, index 1 is requester B.
  logic [4:0]    r_addr [2][DEPTH];
  logic [31:0]   r_data [2][DEPTH];
  logic [PW-1:0] r_rd   [2];
  logic [PW-1:0] r_wr   [2];
  logic [CW-1:0] r_cnt  [2];
  logic          r_last_b;
  logic          r_wr_en;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_grant_b;

  logic [1:0]    w_valid;
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_ne;
  logic [1:0]    w_pop;
  logic [4:0]    w_in_addr [2];
  logic [31:0]   w_in_data [2];
  logic          w_sel;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_pend;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic slot_live(input int idx, input logic [PW-1:0] rd,
                                     input logic [CW-1:0] cnt);
    int off;
    off = idx - int'(rd);
    if (off < 0) off = off + DEPTH;
    return off < int'(cnt);
  endfunction

  assign w_valid      = {b_valid, a_valid};
  assign w_in_addr[0] = a_addr;
  assign w_in_addr[1] = b_addr;
  assign w_in_data[0] = a_data;
  assign w_in_data[1] = b_data;

  always_comb begin
    w_ready = '0;
    w_ne    = '0;
    for (int q = 0; q < 2; q++) begin
      w_ready[q] = r_cnt[q] < FULL_CNT;
      w_ne[q]    = r_cnt[q] != '0;
    end
  end

  assign w_push = w_valid & w_ready;

  // On contention the requester that did not win last time goes; A wins after reset.
  assign w_pop[0]    = w_ne[0] && (!w_ne[1] || r_last_b);
  assign w_pop[1]    = w_ne[1] && !w_pop[0];
  assign w_sel       = w_pop[1];
  assign w_head_addr = r_addr[w_sel][r_rd[w_sel]];
  assign w_head_data = r_data[w_sel][r_rd[w_sel]];

  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (w_push[q]) begin
        r_addr[q][r_wr[q]] <= w_in_addr[q];
        r_data[q][r_wr[q]] <= w_in_data[q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 2; q++) begin
        r_rd[q]  <= '0;
        r_wr[q]  <= '0;
        r_cnt[q] <= '0;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (w_push[q]) r_wr[q] <= next_ptr(r_wr[q]);
        if (w_pop[q])  r_rd[q] <= next_ptr(r_rd[q]);
        if (w_push[q] && !w_pop[q])      r_cnt[q] <= r_cnt[q] + 1'b1;
        else if (!w_push[q] && w_pop[q]) r_cnt[q] <= r_cnt[q] - 1'b1;
      end
    end
  end

  // Address and data follow every pop; writes to r0 are swallowed by wr_en only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_grant_b <= 1'b0;
      r_last_b  <= 1'b1;
    end else begin
      r_wr_en <= (|w_pop) && (w_head_addr != 5'd0);
      if (|w_pop) begin
        r_wr_addr <= w_head_addr;
        r_wr_data <= w_head_data;
        r_grant_b <= w_pop[1];
        r_last_b  <= w_pop[1];
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_live(i, r_rd[q], r_cnt[q])) w_pend[r_addr[q][i]] = 1'b1;
      end
    end
  end

  assign a_ready   = w_ready[0];
  assign b_ready   = w_ready[1];
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign grant_b   = r_grant_b;
  assign pend_mask = {w_pend[31:1], 1'b0};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed write-back scenarios feed an expected-write
// queue; a negedge monitor compares every wr_en cycle against the queue head.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;
  logic        grant_b;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        g;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rf [32];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_mask(pend_mask), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] ad, input logic [31:0] d, input logic g);
    exp_t e;
    e.addr = ad;
    e.data = d;
    e.g    = g;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      rf[wr_addr] = wr_data;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
        chk("grant_b", 32'(grant_b), 32'(e.g));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] ad, input logic [31:0] d);
    int k;
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_ready) break;
    end
    chk("a_accept", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [4:0] ad, input logic [31:0] d);
    int k;
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_ready) break;
    end
    chk("b_accept", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    a_data  = '0;
    b_data  = '0;

    #12;
    chk("rst_a_ready",  32'(a_ready), 32'd1);
    chk("rst_b_ready",  32'(b_ready), 32'd1);
    chk("rst_wr_en",    32'(wr_en),   32'd0);
    chk("rst_wr_addr",  32'(wr_addr), 32'd0);
    chk("rst_wr_data",  wr_data,      32'd0);
    chk("rst_grant_b",  32'(grant_b), 32'd0);
    chk("rst_pend",     pend_mask,    32'd0);

    // Single A write: latency and pending mask
    do_reset();
    expect_wr(5'd5, 32'h0000_00AA, 1'b0);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_00AA;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("s1_pend",        pend_mask,    32'h0000_0020);
    chk("s1_wr_en_early", 32'(wr_en),   32'd0);
    @(negedge clk);
    chk("s1_wr_en",       32'(wr_en),   32'd1);
    chk("s1_pend_clear",  pend_mask,    32'd0);
    wait_drain("s1_drain");

    // Both requesters stream four writes each: strict alternation A,B,A,B...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'(i + 1), 32'h100 + 32'(i), 1'b0);
      expect_wr(5'(i + 9), 32'h900 + 32'(i), 1'b1);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive_a(5'(i + 1), 32'h100 + 32'(i));
      end
      begin
        for (int j = 0; j < 4; j++) drive_b(5'(j + 9), 32'h900 + 32'(j));
      end
    join
    wait_drain("s2_drain");

    // B fills up, a third B request is presented while not ready and must be dropped
    do_reset();
    expect_wr(5'd2, 32'hA1, 1'b0);
    expect_wr(5'd3, 32'hB1, 1'b1);
    expect_wr(5'd4, 32'hA2, 1'b0);
    expect_wr(5'd6, 32'hB2, 1'b1);
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'hA1;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'hB1;
    @(posedge clk); #1;
    a_addr = 5'd4; a_data = 32'hA2;
    b_addr = 5'd6; b_data = 32'hB2;
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_addr = 5'd8; b_data = 32'hB3;
    @(negedge clk);
    chk("s3_b_ready_full", 32'(b_ready), 32'd0);
    chk("s3_a_ready",      32'(a_ready), 32'd1);
    chk("s3_pend_full",    pend_mask,    32'h0000_0058);
    @(posedge clk); #1 b_valid = 1'b0;
    @(negedge clk);
    chk("s3_b_ready_back", 32'(b_ready), 32'd1);
    chk("s3_pend_after",   pend_mask,    32'h0000_0050);
    wait_drain("s3_drain");

    // Write to r0 is consumed silently
    do_reset();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("s4_pend",    pend_mask,   32'd0);
    chk("s4_wr_en0",  32'(wr_en),  32'd0);
    @(negedge clk);
    chk("s4_wr_en1",  32'(wr_en),  32'd0);
    chk("s4_wr_data", wr_data,     32'hFFFF_FFFF);
    chk("s4_pend2",   pend_mask,   32'd0);
    wait_drain("s4_drain");

    // Reset while entries are queued: everything discarded, no stale write later
    do_reset();
    expect_wr(5'd16, 32'h160, 1'b0);
    expect_wr(5'd20, 32'h200, 1'b1);
    a_valid = 1'b1; a_addr = 5'd16; a_data = 32'h160;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h200;
    @(posedge clk); #1;
    a_addr = 5'd17; a_data = 32'h170;
    b_addr = 5'd21; b_data = 32'h210;
    @(posedge clk); #1;
    a_addr = 5'd18; a_data = 32'h180;
    b_valid = 1'b0;
    @(posedge clk); #1;
    a_addr = 5'd19; a_data = 32'h190;
    @(negedge clk);
    chk("s5_pend_pre",    pend_mask,    32'h0026_0000);
    chk("s5_a_full",      32'(a_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_wr_en",   32'(wr_en),   32'd0);
    chk("s5_rst_pend",    pend_mask,    32'd0);
    chk("s5_rst_a_ready", 32'(a_ready), 32'd1);
    chk("s5_rst_b_ready", 32'(b_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (6) @(negedge clk);
    chk("s5_pend_post",   pend_mask,    32'd0);
    wait_drain("s5_drain");

    // Same register from both sides in one cycle: A first, B last
    do_reset();
    expect_wr(5'd7, 32'h11, 1'b0);
    expect_wr(5'd7, 32'h22, 1'b1);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h22;
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("s6_pend0", pend_mask, 32'h0000_0080);
    @(negedge clk);
    chk("s6_pend1", pend_mask, 32'h0000_0080);
    @(negedge clk);
    chk("s6_pend2", pend_mask, 32'd0);
    wait_drain("s6_drain");
    chk("s6_r7_final", rf[7], 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
